// File: rtl/write_controller.sv
// Raster-order frame-buffer writer: turns the synchronized pixel stream into
// registered write strobes/addresses, pulses frame completion, flags malformed input.
module write_controller #(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int ADDR_W = 18,
    parameter int DATA_W = 24
) (
    input  logic              Clk_in,
    input  logic              Rst_in,
    input  logic              pixel_ready,
    input  logic              pixel_valid,
    input  logic              line_end,
    input  logic [DATA_W-1:0] pixel_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              line_err,
    output logic              frame_err
);

    localparam int COL_W = $clog2(IMG_W + 1);
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [COL_W-1:0]  COL_FULL  = COL_W'(IMG_W);
    localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [COL_W-1:0]  col_q, col_d, col_eff;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              line_err_q, line_err_d;
    logic              frame_err_q, frame_err_d;

    always_ff @(posedge Clk_in or posedge Rst_in) begin
        if (Rst_in) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            line_base_q  <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            line_base_q  <= line_base_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // A pixel_ready seen mid-frame restarts capture rather than ending it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pixel_ready && pixel_valid) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (!pixel_ready && line_end && row_q == ROW_LAST) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        col_d        = col_q;
        col_eff      = col_q;
        row_d        = row_q;
        line_base_d  = line_base_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        busy_d       = (state_d == CAPTURE);
        frame_done_d = 1'b0;
        line_err_d   = line_err_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            IDLE: begin
                if (pixel_ready && pixel_valid) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = '0;
                    wr_data_d   = pixel_data;
                    col_d       = COL_ONE;
                    row_d       = '0;
                    line_base_d = '0;
                end
            end
            CAPTURE: begin
                if (pixel_ready) begin
                    frame_err_d = 1'b1;
                    row_d       = '0;
                    line_base_d = '0;
                    col_d       = '0;
                    if (pixel_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = '0;
                        wr_data_d = pixel_data;
                        col_d     = COL_ONE;
                    end
                end else begin
                    // Same-cycle pixel is counted before line_end checks the row length.
                    if (pixel_valid) begin
                        if (col_q < COL_FULL) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = line_base_q + ADDR_W'(col_q);
                            wr_data_d = pixel_data;
                            col_eff   = col_q + COL_ONE;
                        end else begin
                            line_err_d = 1'b1;
                        end
                    end
                    if (line_end) begin
                        if (col_eff != COL_FULL) line_err_d = 1'b1;
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d       = '0;
                            line_base_d = '0;
                        end else begin
                            row_d       = row_q + ROW_ONE;
                            line_base_d = line_base_q + LINE_STEP;
                        end
                    end else begin
                        col_d = col_eff;
                    end
                end
            end
            DONE: begin
                frame_done_d = 1'b1;
                col_d        = '0;
                row_d        = '0;
                line_base_d  = '0;
            end
            default: begin
                col_d       = '0;
                row_d       = '0;
                line_base_d = '0;
            end
        endcase
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign line_err   = line_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: doc/write_controller.md
Name: write_controller

Overview:
- Consumes the synchronized pixel stream from the input interface (pixel_ready, pixel_valid, line_end, pixel_data).
- Writes each pixel into the single-port frame buffer in raster order and generates the write address.
- Signals frame completion to the rotation/read stage.
- Detects malformed lines and frames and reports them through sticky error flags.

Parameters:
- IMG_W, 512, pixels per row.
- IMG_H, 512, rows per frame.
- ADDR_W, 18, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- DATA_W, 24, pixel width (RGB888).

Ports:
- Clk_in  input  1  system clock, 100 MHz, rising edge.
- Rst_in  input  1  asynchronous active-high reset.
- pixel_ready  input  1  start-of-frame, coincident with the first pixel of a frame.
- pixel_valid  input  1  valid pixel on pixel_data this cycle.
- line_end  input  1  end-of-row marker, single cycle.
- pixel_data  input  DATA_W  pixel value.
- wr_en  output  1  frame-buffer write strobe.
- wr_addr  output  ADDR_W  frame-buffer write address.
- wr_data  output  DATA_W  frame-buffer write data.
- busy  output  1  high while a frame is being captured.
- frame_done  output  1  one-cycle pulse after the last row is captured.
- line_err  output  1  sticky: a row was short or overlong.
- frame_err  output  1  sticky: pixel_ready arrived mid-frame.

Behaviour:
- Reset (async, immediate): all outputs 0; state=IDLE; col=0, row=0, line_base=0.
- Outputs are registered. The write for a pixel sampled at edge N appears on wr_en/wr_addr/wr_data during cycle N+1.
- Address = line_base + col. line_base advances by IMG_W at each line_end. No multiplier.
- State IDLE:
  - pixel_ready&&pixel_valid: write addr 0, col=1, row=0, busy=1, go CAPTURE.
  - pixel_valid without pixel_ready: ignored, no write.
  - line_end: ignored.
- State CAPTURE, pixel_valid:
  - col<IMG_W: write line_base+col, col++.
  - col==IMG_W (overlong row): pixel dropped, no write, line_err=1.
- State CAPTURE, line_end:
  - If col!=IMG_W after counting any same-cycle pixel, line_err=1.
  - col=0, row++, line_base+=IMG_W.
- Same-cycle pixel_valid and line_end: the pixel is written at the current col first, then the row advances.
- Last row: line_end on row==IMG_H-1 goes to DONE. The final pixel's write still issues on the next cycle.
- State DONE (one cycle): frame_done=1, busy=0, counters and line_base cleared, go IDLE.
  - pixel_valid arriving in DONE is ignored.
  - A new frame is accepted from IDLE onward.
- pixel_ready while in CAPTURE:
  - frame_err=1 and the frame restarts: this pixel is written at addr 0, col=1, row=0, line_base=0.
  - frame_done is not pulsed for the aborted frame.
- Sticky errors clear only on Rst_in.
- Reset mid-frame: wr_en drops immediately and no further writes occur until the next pixel_ready.
- Address never exceeds IMG_W*IMG_H-1 under any input sequence.

Test Plan:
- Nominal frame, IMG_W=4, IMG_H=3 (12 pixels, 3 line_end) -> writes to addr 0..11 in order, each wr_data equals its input one cycle later; frame_done pulses once, 1 cycle after the final write; no errors.
- pixel_valid stream with pixel_ready never asserted -> wr_en stays 0, busy=0.
- Row of 5 pixels with IMG_W=4 -> 5th pixel not written, line_err=1; next row starts at addr 4.
- Short row of 3 pixels then line_end -> line_err=1; next row's first write at addr 4, not addr 3.
- pixel_ready asserted on pixel 6 of the frame -> frame_err=1; that pixel written at addr 0; a full frame after that completes with a single frame_done.
- Rst_in asserted mid-row, then a fresh frame -> outputs 0 asynchronously; the new frame writes from addr 0 with errors cleared.
